// File: rtl/multi_reset_gen.sv
// multi_reset_gen: N-channel reset pulse generator for open-drain active-low
// reset pins (console, auxiliary devices), clocked in the reset domain.
//
// Ports:
//   clock        reset-domain clock
//   reset        synchronous active-high reset
//   trigger      one-cycle request per channel (already synchronised)
//   hold         level; keeps a channel asserted while high
//   pulse_len    per-channel length, channel i at [i*W +: W]; 0 = default
//   nreset_drive 1 = pull the channel's reset pin low
//   busy         channel is asserting or cooling down
//   done         one-cycle pulse in the first cycle the pin is released
//   dropped      one-cycle pulse when a trigger is ignored in cooldown

module multi_reset_gen_channel #(
    parameter int COUNTER_WIDTH  = 24,
    parameter int DEFAULT_PULSE  = 8_000_000,
    parameter int COOLDOWN       = 1_000_000,
    parameter int POWERON_ASSERT = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     trigger,
    input  logic                     hold,
    input  logic [COUNTER_WIDTH-1:0] pulse_len,
    output logic                     nreset_drive,
    output logic                     busy,
    output logic                     done,
    output logic                     dropped
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_COOL   = 2'd2;

    localparam logic [COUNTER_WIDTH-1:0] ONE =
        COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] DEF_LEN =
        COUNTER_WIDTH'(DEFAULT_PULSE);
    localparam logic [COUNTER_WIDTH-1:0] COOL_LAST =
        COUNTER_WIDTH'(COOLDOWN - 1);
    localparam bit HAS_COOL = (COOLDOWN != 0);
    localparam bit PWR_ON   = (POWERON_ASSERT != 0);

    // Power-on assertion behaves as if a default-length request had been
    // accepted on every reset edge, so the pulse runs out after release.
    localparam logic [1:0] RST_STATE = PWR_ON ? ST_ASSERT : ST_IDLE;
    localparam logic [COUNTER_WIDTH-1:0] RST_CNT =
        PWR_ON ? (DEF_LEN - ONE) : '0;

    logic [1:0]               state_q;
    logic [1:0]               state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_d;
    logic [COUNTER_WIDTH-1:0] len_last;
    logic                     done_d;
    logic                     drop_d;
    logic                     counting;

    // Counter holds "cycles remaining minus one", so load L-1.
    assign len_last = (pulse_len == '0) ? (DEF_LEN - ONE)
                                        : (pulse_len - ONE);

    assign counting = (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger || hold) begin
                    state_d = ST_ASSERT;
                    cnt_d   = len_last;
                end
            end
            ST_ASSERT: begin
                if (trigger) begin
                    // Retrigger restarts the count; the pin never drops.
                    cnt_d = len_last;
                end else if (hold) begin
                    cnt_d = cnt_q;
                end else if (counting) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    done_d = 1'b1;
                    if (HAS_COOL) begin
                        state_d = ST_COOL;
                        cnt_d   = COOL_LAST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_COOL: begin
                if (counting) begin
                    cnt_d  = cnt_q - ONE;
                    drop_d = trigger;
                end else if (trigger || hold) begin
                    // Last cooldown cycle: a request here is the earliest
                    // one that may be honoured, L+COOLDOWN after the
                    // previous accept.
                    state_d = ST_ASSERT;
                    cnt_d   = len_last;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RST_STATE;
            cnt_q        <= RST_CNT;
            nreset_drive <= PWR_ON;
            busy         <= PWR_ON;
            done         <= 1'b0;
            dropped      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nreset_drive <= (state_d == ST_ASSERT);
            busy         <= (state_d != ST_IDLE);
            done         <= done_d;
            dropped      <= drop_d;
        end
    end

endmodule

module multi_reset_gen #(
    parameter int CHANNELS       = 2,
    parameter int COUNTER_WIDTH  = 24,
    parameter int DEFAULT_PULSE  = 8_000_000,
    parameter int COOLDOWN       = 1_000_000,
    parameter int POWERON_ASSERT = 0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [CHANNELS-1:0]               trigger,
    input  logic [CHANNELS-1:0]               hold,
    input  logic [CHANNELS*COUNTER_WIDTH-1:0] pulse_len,
    output logic [CHANNELS-1:0]               nreset_drive,
    output logic [CHANNELS-1:0]               busy,
    output logic [CHANNELS-1:0]               done,
    output logic [CHANNELS-1:0]               dropped
);

    localparam longint MAX_COUNT =
        (longint'(1) << COUNTER_WIDTH) - longint'(1);

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("multi_reset_gen: CHANNELS must be 1..8");
    end

    if (COUNTER_WIDTH < 1 || COUNTER_WIDTH > 32) begin : g_bad_width
        $error("multi_reset_gen: COUNTER_WIDTH must be 1..32");
    end

    if (DEFAULT_PULSE < 1 ||
        longint'(DEFAULT_PULSE) > MAX_COUNT) begin : g_bad_pulse
        $error("multi_reset_gen: DEFAULT_PULSE out of counter range");
    end

    if (COOLDOWN < 0 ||
        longint'(COOLDOWN) > MAX_COUNT) begin : g_bad_cool
        $error("multi_reset_gen: COOLDOWN out of counter range");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        multi_reset_gen_channel #(
            .COUNTER_WIDTH  (COUNTER_WIDTH),
            .DEFAULT_PULSE  (DEFAULT_PULSE),
            .COOLDOWN       (COOLDOWN),
            .POWERON_ASSERT (POWERON_ASSERT)
        ) u_chan (
            .clock        (clock),
            .reset        (reset),
            .trigger      (trigger[i]),
            .hold         (hold[i]),
            .pulse_len    (pulse_len[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
            .nreset_drive (nreset_drive[i]),
            .busy         (busy[i]),
            .done         (done[i]),
            .dropped      (dropped[i])
        );
    end

endmodule
